// File: rtl/tnn_compress_pkg.sv
// rtl/tnn_compress_pkg.sv - shared trit encoding types and helpers for the ternary compression path
package tnn_compress_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_ZERO = 2'b00;
    localparam trit_t TRIT_POS  = 2'b01;
    localparam trit_t TRIT_NEG  = 2'b11;

    typedef enum logic {
        DEC_IDLE = 1'b0,
        DEC_EMIT = 1'b1
    } dec_state_e;

    function automatic int unsigned pow3(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 3;
        end
        return p;
    endfunction

endpackage

// File: rtl/trit_divmod3.sv
// rtl/trit_divmod3.sv - combinational divide-by-3 with remainder
// Restoring long division: the running remainder never exceeds 2, so it fits in 2 bits between steps.
module trit_divmod3
    import tnn_compress_pkg::*;
#(
    parameter int COMP_WIDTH = 8
) (
    input  logic [COMP_WIDTH-1:0] num_i,
    output logic [COMP_WIDTH-1:0] quot_o,
    output logic [1:0]            rem_o
);

    logic [2:0] acc;

    always_comb begin
        quot_o = '0;
        acc    = '0;
        for (int i = COMP_WIDTH - 1; i >= 0; i--) begin
            acc = {acc[1:0], num_i[i]};
            if (acc >= 3'd3) begin
                quot_o[i] = 1'b1;
                acc       = acc - 3'd3;
            end
        end
        rem_o = acc[1:0];
    end

endmodule

// File: rtl/ternary_decompress.sv
// rtl/ternary_decompress.sv - streams the base-3 packed trits of each compressed word, one per cycle
module ternary_decompress
    import tnn_compress_pkg::*;
#(
    parameter int N_TRITS    = 5,
    parameter int COMP_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [COMP_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output trit_t                 trit_o,
    output logic                  trit_valid_o,
    input  logic                  trit_ready_i,
    output logic                  last_o,
    output logic                  invalid_o
);

    localparam int unsigned MAX_CODE = pow3(N_TRITS);
    localparam int CNT_W = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TRITS - 1);
    localparam logic [COMP_WIDTH:0] MAX_CODE_W = (COMP_WIDTH + 1)'(MAX_CODE);

    if (longint'(MAX_CODE) > (longint'(1) << COMP_WIDTH)) begin : g_width_check
        $error("ternary_decompress: 3**N_TRITS does not fit in COMP_WIDTH bits");
    end

    dec_state_e             state_q, state_d;
    logic [COMP_WIDTH-1:0]  r_q, r_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   inv_q, inv_d;

    logic [COMP_WIDTH-1:0]  quot;
    logic [1:0]             rem;
    logic                   emit;
    logic                   accept;
    logic                   trit_fire;

    trit_divmod3 #(.COMP_WIDTH(COMP_WIDTH)) u_divmod3 (
        .num_i  (r_q),
        .quot_o (quot),
        .rem_o  (rem)
    );

    // Outputs are forced quiet while reset is asserted, even before the state register clears.
    assign emit         = (state_q == DEC_EMIT) && !rst_i;
    assign trit_valid_o = emit;
    assign last_o       = emit && (cnt_q == CNT_LAST);
    assign invalid_o    = emit && inv_q;
    assign trit_fire    = trit_valid_o && trit_ready_i;
    assign ready_o      = !rst_i && ((state_q == DEC_IDLE) || (trit_fire && last_o));
    assign accept       = valid_i && ready_o;

    always_comb begin
        trit_o = TRIT_ZERO;
        if (emit && !inv_q) begin
            case (rem)
                2'd0:    trit_o = TRIT_NEG;
                2'd1:    trit_o = TRIT_ZERO;
                default: trit_o = TRIT_POS;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        if (trit_fire) begin
            if (!last_o) begin
                r_d   = quot;
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                state_d = DEC_IDLE;
            end
        end
        // Accept is only possible from IDLE or on the last trit handshake, so it overrides the above.
        if (accept) begin
            state_d = DEC_EMIT;
            r_d     = data_i;
            cnt_d   = '0;
            inv_d   = ({1'b0, data_i} >= MAX_CODE_W);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DEC_IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
        end
    end

endmodule

// File: tb/tb_ternary_decompress.sv
// tb/tb_ternary_decompress.sv - scoreboarded bench for ternary_decompress
module tb_ternary_decompress;
    import tnn_compress_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_o;
    trit_t      trit_o;
    logic       trit_valid_o;
    logic       trit_ready_i = 1'b0;
    logic       last_o;
    logic       invalid_o;

    always #5 clk = ~clk;

    ternary_decompress #(.N_TRITS(5), .COMP_WIDTH(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .trit_o       (trit_o),
        .trit_valid_o (trit_valid_o),
        .trit_ready_i (trit_ready_i),
        .last_o       (last_o),
        .invalid_o    (invalid_o)
    );

    typedef struct {
        logic [7:0] word;
        logic [9:0] trits;
        logic       inv;
    } vec_t;

    typedef struct packed {
        logic [1:0] trit;
        logic       last;
        logic       inv;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input vec_t v);
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            e.trit = v.trits[2*k +: 2];
            e.last = (k == 4);
            e.inv  = v.inv;
            sb.push_back(e);
        end
    endtask

    // Called right after a negedge; returns at the negedge after the accepting edge (trit 0 visible).
    task automatic send(input vec_t v, output int waits);
        data_i  = v.word;
        valid_i = 1'b1;
        #1;
        waits = 0;
        while (!ready_o && waits < 50) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!ready_o) begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout: word %h not accepted after %0d cycles", v.word, waits);
        end else begin
            push_word(v);
        end
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() > 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: %0d trits outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: sample late in the low phase, when the handshake for the coming edge is settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (trit_valid_o && trit_ready_i) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_trit: got trit=%b last=%b inv=%b, required no trit", trit_o, last_o, invalid_o);
                end else begin
                    e = sb.pop_front();
                    if ({trit_o, last_o, invalid_o} !== e) begin
                        n_miss++;
                        $display("FAIL trit_stream: got trit=%b last=%b inv=%b, required trit=%b last=%b inv=%b",
                                 trit_o, last_o, invalid_o, e.trit, e.last, e.inv);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int w2;
        vt[0] = '{8'hC2, 10'b01_00_11_00_01, 1'b0};
        vt[1] = '{8'h00, 10'b11_11_11_11_11, 1'b0};
        vt[2] = '{8'hF2, 10'b01_01_01_01_01, 1'b0};
        vt[3] = '{8'hF3, 10'b00_00_00_00_00, 1'b1};
        vt[4] = '{8'hFF, 10'b00_00_00_00_00, 1'b1};
        vt[5] = '{8'h01, 10'b11_11_11_11_00, 1'b0};
        vt[6] = '{8'h79, 10'b00_00_00_00_00, 1'b0};
        vt[7] = '{8'h51, 10'b00_11_11_11_11, 1'b0};
        vt[8] = '{8'h2D, 10'b11_00_01_11_11, 1'b0};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready_o), 0);
        chk("rst_valid", 32'(trit_valid_o), 0);
        chk("rst_trit", 32'(trit_o), 0);
        chk("rst_last", 32'(last_o), 0);
        chk("rst_invalid", 32'(invalid_o), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(ready_o), 1);
        chk("idle_valid", 32'(trit_valid_o), 0);

        // Table of words streamed back to back with no backpressure.
        @(negedge clk);
        trit_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(vt[i], w);
        end
        drain();

        // Backpressure: stall three cycles while trit 1 of 0xC2 is shown.
        @(negedge clk);
        send(vt[0], w);
        @(negedge clk);
        trit_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_trit", 32'(trit_o), 32'(2'b00));
            chk("stall_last", 32'(last_o), 0);
            chk("stall_valid", 32'(trit_valid_o), 1);
            chk("stall_ready", 32'(ready_o), 0);
            @(negedge clk);
        end
        trit_ready_i = 1'b1;
        drain();

        // Back to back: 0xC2 then 0x00, second word accepted on the first word's last trit.
        @(negedge clk);
        send(vt[0], w);
        chk("b2b_first_wait", 32'(w), 0);
        send(vt[1], w2);
        chk("b2b_ready_on_last", 32'(w2), 4);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("b2b_no_bubble", 32'(trit_valid_o), 1);
            @(negedge clk);
        end
        drain();

        // Reset after trit 2 of 0xC2 discards the rest of the word.
        @(negedge clk);
        send(vt[0], w);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready_o), 0);
        chk("midrst_valid", 32'(trit_valid_o), 0);
        chk("midrst_trit", 32'(trit_o), 0);
        chk("midrst_last", 32'(last_o), 0);
        chk("midrst_invalid", 32'(invalid_o), 0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_discarded", 32'(sb.size()), 2);
        sb.delete();
        #1;
        chk("midrst_ready_after", 32'(ready_o), 1);
        chk("midrst_no_stale", 32'(trit_valid_o), 0);
        @(negedge clk);
        send(vt[1], w);
        drain();
        @(negedge clk);
        #1;
        chk("final_idle", 32'(trit_valid_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
